// File: rtl/obstacle_slot_pkg.sv
// obstacle_slot_pkg
// Shared definitions for the obstacle slot driver: the FSM state encoding,
// the sprite-core register offsets and the slot bus geometry, plus a helper
// that builds a register-space slot address from an offset.
package obstacle_slot_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UPLOAD,
      ST_F_BYP,
      ST_F_X0,
      ST_F_Y0,
      ST_F_CTRL
   } state_e;

   // Register offsets inside the sprite core's register space
   localparam logic [1:0] REG_BYPASS = 2'b00;
   localparam logic [1:0] REG_X0     = 2'b01;
   localparam logic [1:0] REG_Y0     = 2'b10;
   localparam logic [1:0] REG_CTRL   = 2'b11;

   // addr bit that separates register space (1) from sprite RAM (0)
   localparam int REG_SPACE = 13;

   localparam int SLOT_AW = 14;
   localparam int SLOT_DW = 32;

   function automatic logic [SLOT_AW-1:0] reg_addr(input logic [1:0] off);
      logic [SLOT_AW-1:0] a;
      a            = '0;
      a[REG_SPACE] = 1'b1;
      a[1:0]       = off;
      return a;
   endfunction

endpackage

// File: rtl/obstacle_slot_driver_if.sv
// obstacle_slot_driver_if
// Video-slot write bus of the obstacle sprite core.
//   cs, write : strobes, asserted together for one cycle per write
//   addr      : slot address (bit 13 selects register space)
//   wr_data   : slot write data
// master = bus initiator (the driver), slave = sprite core.
interface obstacle_slot_driver_if;
   import obstacle_slot_pkg::*;

   logic               cs;
   logic               write;
   logic [SLOT_AW-1:0] addr;
   logic [SLOT_DW-1:0] wr_data;

   modport master (output cs, output write, output addr, output wr_data);
   modport slave  (input  cs, input  write, input  addr, input  wr_data);

endinterface

// File: rtl/obstacle_slot_driver_stepper.sv
// slot_x_stepper
// Combinational horizontal step of the obstacle: moves x0 left by speed,
// and wraps back to X_START when the step would pass the left edge.
//   x0_cur  in  11  current x0
//   speed   in  4   pixels per frame (0 = hold)
//   x0_next out 11  new x0
module slot_x_stepper #(
   parameter int X_START = 640
) (
   input  logic [10:0] x0_cur,
   input  logic [3:0]  speed,
   output logic [10:0] x0_next
);

   localparam logic [10:0] X_START_V = 11'(X_START);

   logic        wrap;
   logic [10:0] speed_ext;

   always_comb begin
      speed_ext = {7'd0, speed};
      wrap      = (x0_cur < speed_ext);
      x0_next   = wrap ? X_START_V : (x0_cur - speed_ext);
   end

endmodule

// File: rtl/obstacle_slot_driver.sv
// obstacle_slot_driver
// Bus initiator for the obstacle sprite core. Once per frame (x==0,
// y==TRIG_Y) it steps the obstacle left and writes bypass/x0/y0/ctrl; on
// request it copies a 2-bit pixel ROM into the core's sprite RAM.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   x, y                  frame counter
//   enable, speed         show/move enable, pixels per frame
//   y_pos, ctrl           values written to y0 / ctrl
//   upload_start          one-cycle upload request
//   rom_addr, rom_data    pixel ROM port (data one cycle after address)
//   bus                   slot write bus (master side)
//   busy                  high whenever not idle
//   frame_done            pulse with the last register write of a frame
//   upload_done           pulse with the last RAM write of an upload
module obstacle_slot_driver
   import obstacle_slot_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int TRIG_Y     = 480,
   parameter int X_START    = 640
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [10:0]             x,
   input  logic [10:0]             y,
   input  logic                    enable,
   input  logic [3:0]              speed,
   input  logic [10:0]             y_pos,
   input  logic [4:0]              ctrl,
   input  logic                    upload_start,
   output logic [ADDR_WIDTH-1:0]   rom_addr,
   input  logic [1:0]              rom_data,
   obstacle_slot_driver_if.master  bus,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    upload_done
);

   state_e                 state_q, state_d;
   logic                   trig_pend_q, trig_pend_d;
   logic                   up_pend_q, up_pend_d;
   logic [10:0]            x0_q, x0_d;
   logic [10:0]            y0_q, y0_d;
   logic [4:0]             ctrl_q, ctrl_d;
   logic                   en_q, en_d;
   logic [ADDR_WIDTH-1:0]  rom_addr_q, rom_addr_d;
   logic                   up_last_q, up_last_d;
   logic                   cs_q, cs_d;
   logic                   ram_wr_q, ram_wr_d;
   logic [SLOT_AW-1:0]     addr_q, addr_d;
   logic [SLOT_DW-1:0]     data_q, data_d;
   logic                   busy_q, busy_d;
   logic                   frame_done_q, frame_done_d;
   logic                   upload_done_q, upload_done_d;

   logic                   trig;
   logic                   up_req;
   logic                   trig_req;
   logic [10:0]            x0_step;

   slot_x_stepper #(.X_START(X_START)) u_stepper (
      .x0_cur  (x0_q),
      .speed   (speed),
      .x0_next (x0_step)
   );

   assign trig     = (x == 11'd0) && (y == 11'(TRIG_Y));
   assign up_req   = up_pend_q | upload_start;
   assign trig_req = trig_pend_q | trig;

   always_comb begin
      state_d       = state_q;
      // A trigger is remembered unless the IDLE branch below consumes it
      trig_pend_d   = trig_pend_q | trig;
      up_pend_d     = up_pend_q;
      x0_d          = x0_q;
      y0_d          = y0_q;
      ctrl_d        = ctrl_q;
      en_d          = en_q;
      rom_addr_d    = rom_addr_q;
      up_last_d     = up_last_q;
      cs_d          = 1'b0;
      ram_wr_d      = 1'b0;
      addr_d        = '0;
      data_d        = '0;
      frame_done_d  = 1'b0;
      upload_done_d = 1'b0;

      // Bus outputs are computed for the state being entered, so each
      // state's write is visible on the bus during that state.
      case (state_q)
         ST_IDLE: begin
            if (up_req) begin
               state_d    = ST_UPLOAD;
               up_pend_d  = 1'b0;
               rom_addr_d = '0;
               up_last_d  = 1'b0;
            end else if (trig_req) begin
               state_d      = ST_F_BYP;
               trig_pend_d  = 1'b0;
               en_d         = enable;
               y0_d         = y_pos;
               ctrl_d       = ctrl;
               if (enable) begin
                  x0_d = x0_step;
               end
               cs_d         = 1'b1;
               addr_d       = reg_addr(REG_BYPASS);
               data_d       = {31'd0, ~enable};
               frame_done_d = ~enable;
            end
         end

         ST_UPLOAD: begin
            // upload_start is deliberately not recorded here
            if (!up_last_q) begin
               cs_d                     = 1'b1;
               ram_wr_d                 = 1'b1;
               addr_d[ADDR_WIDTH-1:0]   = rom_addr_q;
               if (rom_addr_q == '1) begin
                  up_last_d     = 1'b1;
                  upload_done_d = 1'b1;
               end else begin
                  rom_addr_d = rom_addr_q + 1'b1;
               end
            end else begin
               state_d    = ST_IDLE;
               up_last_d  = 1'b0;
               rom_addr_d = '0;
            end
         end

         ST_F_BYP: begin
            up_pend_d = up_req;
            if (en_q) begin
               state_d = ST_F_X0;
               cs_d    = 1'b1;
               addr_d  = reg_addr(REG_X0);
               data_d  = {21'd0, x0_q};
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_F_X0: begin
            up_pend_d = up_req;
            state_d   = ST_F_Y0;
            cs_d      = 1'b1;
            addr_d    = reg_addr(REG_Y0);
            data_d    = {21'd0, y0_q};
         end

         ST_F_Y0: begin
            up_pend_d    = up_req;
            state_d      = ST_F_CTRL;
            cs_d         = 1'b1;
            addr_d       = reg_addr(REG_CTRL);
            data_d       = {27'd0, ctrl_q};
            frame_done_d = 1'b1;
         end

         ST_F_CTRL: begin
            up_pend_d = up_req;
            state_d   = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         trig_pend_q   <= 1'b0;
         up_pend_q     <= 1'b0;
         x0_q          <= 11'(X_START);
         y0_q          <= '0;
         ctrl_q        <= '0;
         en_q          <= 1'b0;
         rom_addr_q    <= '0;
         up_last_q     <= 1'b0;
         cs_q          <= 1'b0;
         ram_wr_q      <= 1'b0;
         addr_q        <= '0;
         data_q        <= '0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         upload_done_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         trig_pend_q   <= trig_pend_d;
         up_pend_q     <= up_pend_d;
         x0_q          <= x0_d;
         y0_q          <= y0_d;
         ctrl_q        <= ctrl_d;
         en_q          <= en_d;
         rom_addr_q    <= rom_addr_d;
         up_last_q     <= up_last_d;
         cs_q          <= cs_d;
         ram_wr_q      <= ram_wr_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         busy_q        <= busy_d;
         frame_done_q  <= frame_done_d;
         upload_done_q <= upload_done_d;
      end
   end

   assign rom_addr    = rom_addr_q;
   assign bus.cs      = cs_q;
   assign bus.write   = cs_q;
   assign bus.addr    = addr_q;
   // The pixel for a RAM write comes straight off the (registered) ROM
   // output in the write cycle: it belongs to the index issued one cycle
   // earlier, which is exactly the index now on addr.
   assign bus.wr_data = data_q | {30'd0, (ram_wr_q ? rom_data : 2'b00)};
   assign busy        = busy_q;
   assign frame_done  = frame_done_q;
   assign upload_done = upload_done_q;

endmodule

// File: tb/tb_obstacle_slot_driver.sv
module tb_obstacle_slot_driver;

   localparam int AW      = 10;
   localparam int N       = 1 << AW;
   localparam int TRIG_Y  = 480;
   localparam int X_START = 640;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [10:0]   x = 11'd5;
   logic [10:0]   y = 11'd0;
   logic          enable = 1'b0;
   logic [3:0]    speed = 4'd0;
   logic [10:0]   y_pos = 11'd0;
   logic [4:0]    ctrl = 5'd0;
   logic          upload_start = 1'b0;
   logic [AW-1:0] rom_addr;
   logic [1:0]    rom_data = 2'b00;
   logic          busy, frame_done, upload_done;
   logic [1:0]    rom_key = 2'b00;

   obstacle_slot_driver_if bus ();

   obstacle_slot_driver #(
      .ADDR_WIDTH (AW),
      .TRIG_Y     (TRIG_Y),
      .X_START    (X_START)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .x            (x),
      .y            (y),
      .enable       (enable),
      .speed        (speed),
      .y_pos        (y_pos),
      .ctrl         (ctrl),
      .upload_start (upload_start),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .bus          (bus),
      .busy         (busy),
      .frame_done   (frame_done),
      .upload_done  (upload_done)
   );

   always #5 clk = ~clk;

   // Registered pixel ROM: data for an address appears the following cycle
   always @(posedge clk) rom_data <= rom_addr[1:0] ^ rom_key;

   typedef struct packed {
      logic [31:0] cyc;
      logic        cs;
      logic        wr;
      logic [13:0] addr;
      logic [31:0] data;
      logic        fd;
      logic        ud;
   } wr_t;

   wr_t got_q[$];
   wr_t exp_q[$];
   bit  busy_hist [int];
   int  cyc = 0;
   int  n_checks = 0;
   int  n_pass = 0;
   int  x0m;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.cs || bus.write || frame_done || upload_done)
         got_q.push_back({cyc[31:0], bus.cs, bus.write, bus.addr, bus.wr_data, frame_done, upload_done});
      busy_hist[cyc] = busy;
   end

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
         $display("ok   %s : %h", tag, obs);
      end else begin
         $display("FAIL %s : got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic wr_t mk(input int c, input int a, input int d, input logic fd, input logic ud);
      wr_t r;
      r.cyc  = 32'(c);
      r.cs   = 1'b1;
      r.wr   = 1'b1;
      r.addr = 14'(a);
      r.data = 32'(d);
      r.fd   = fd;
      r.ud   = ud;
      return r;
   endfunction

   // Expected frame sequence taken from IDLE in cycle t
   task automatic exp_frame(input int t, input logic en, input int spd, input int yp, input int ct);
      if (en) begin
         if (x0m >= spd) x0m = x0m - spd;
         else            x0m = X_START;
         exp_q.push_back(mk(t + 1, 'h2000, 0,   1'b0, 1'b0));
         exp_q.push_back(mk(t + 2, 'h2001, x0m, 1'b0, 1'b0));
         exp_q.push_back(mk(t + 3, 'h2002, yp,  1'b0, 1'b0));
         exp_q.push_back(mk(t + 4, 'h2003, ct,  1'b1, 1'b0));
      end else begin
         exp_q.push_back(mk(t + 1, 'h2000, 1, 1'b1, 1'b0));
      end
   endtask

   // Expected upload accepted in IDLE in cycle t
   task automatic exp_upload(input int t, input int key);
      for (int i = 0; i < N; i++)
         exp_q.push_back(mk(t + 2 + i, i, (i & 3) ^ key, 1'b0, i == N - 1));
   endtask

   task automatic compare(input string tag);
      chk({tag, "_count"}, 96'(got_q.size()), 96'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk(tag, 96'(got_q[i]), 96'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic noise();
      x = 11'($urandom_range(0, 799));
      y = 11'($urandom_range(0, 524));
      if (x == 11'd0 && y == 11'(TRIG_Y)) y = 11'd0;
      upload_start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         noise();
      end
   endtask

   task automatic trig(output int t);
      @(negedge clk);
      noise();
      x = 11'd0;
      y = 11'(TRIG_Y);
      t = cyc;
   endtask

   task automatic upl(output int t);
      @(negedge clk);
      noise();
      upload_start = 1'b1;
      t = cyc;
   endtask

   task automatic set_in(input logic en, input int spd, input int yp, input int ct);
      @(negedge clk);
      noise();
      enable = en;
      speed  = 4'(spd);
      y_pos  = 11'(yp);
      ctrl   = 5'(ct);
   endtask

   task automatic do_frame(input logic en, input int spd, input int yp, input int ct, input string tag);
      int t;
      set_in(en, spd, yp, ct);
      trig(t);
      exp_frame(t, en, spd, yp, ct);
      idle(7);
      compare(tag);
      chk({tag, "_busy"}, 96'(busy), 96'(0));
   endtask

   initial begin
      int t, t1, t2, spd;

      // Reset state
      idle(3);
      chk("rst_cs",          96'(bus.cs),      96'(0));
      chk("rst_write",       96'(bus.write),   96'(0));
      chk("rst_addr",        96'(bus.addr),    96'(0));
      chk("rst_wr_data",     96'(bus.wr_data), 96'(0));
      chk("rst_rom_addr",    96'(rom_addr),    96'(0));
      chk("rst_busy",        96'(busy),        96'(0));
      chk("rst_frame_done",  96'(frame_done),  96'(0));
      chk("rst_upload_done", 96'(upload_done), 96'(0));
      @(negedge clk);
      reset = 1'b1;
      x0m   = X_START;
      idle(2);

      // First frame: 0, 635, 100, 4
      do_frame(1'b1, 5, 100, 4, "first");

      // Walk x0 down to 3, then wrap and step again
      for (int k = 0; k < 200 && x0m != 3; k++) begin
         spd = (x0m >= 18) ? 15 : ((x0m > 3) ? x0m - 3 : 15);
         do_frame(1'b1, spd, $urandom_range(0, 2047), $urandom_range(0, 31), "walk");
      end
      do_frame(1'b1, 5, 300, 17, "wrap");
      do_frame(1'b1, 5, 301, 18, "after_wrap");

      // Disabled frame holds x0; speed 0 holds x0
      do_frame(1'b0, 7, 12, 3, "disabled");
      do_frame(1'b1, 7, 13, 6, "enabled_after_disabled");
      do_frame(1'b1, 0, 14, 7, "speed0");

      // Randomized frames
      for (int k = 0; k < 25; k++)
         do_frame($urandom_range(0, 3) != 0, $urandom_range(0, 15),
                  $urandom_range(0, 2047), $urandom_range(0, 31), "rand");

      // Plain upload, pixel = index[1:0]
      rom_key = 2'b00;
      upl(t);
      exp_upload(t, 0);
      while (cyc < t + N + 8) idle(1);
      compare("upload");
      chk("upload_busy_last", 96'(busy_hist[t + 1 + N]), 96'(1));
      chk("upload_busy_low",  96'(busy_hist[t + 2 + N]), 96'(0));

      // Two triggers and an ignored upload_start during an upload
      set_in(1'b1, 3, 200, 9);
      rom_key = 2'b10;
      upl(t);
      idle(99);
      trig(t1);
      idle(200);
      upl(t2);
      idle(200);
      trig(t1);
      exp_upload(t, 2);
      exp_frame(t + 2 + N, 1'b1, 3, 200, 9);
      while (cyc < t + N + 20) idle(1);
      compare("upload_trig");

      // upload_start during a frame sequence is served right after it
      rom_key = 2'b01;
      set_in(1'b1, 4, 55, 21);
      trig(t);
      upl(t2);
      exp_frame(t, 1'b1, 4, 55, 21);
      exp_upload(t + 5, 1);
      while (cyc < t + N + 20) idle(1);
      compare("frame_then_upload");

      // Trigger and upload in the same IDLE cycle: upload first
      rom_key = 2'b11;
      set_in(1'b1, 6, 77, 30);
      @(negedge clk);
      noise();
      x = 11'd0;
      y = 11'(TRIG_Y);
      upload_start = 1'b1;
      t = cyc;
      exp_upload(t, 3);
      exp_frame(t + 2 + N, 1'b1, 6, 77, 30);
      while (cyc < t + N + 20) idle(1);
      compare("simultaneous");

      // Second trigger during a frame sequence runs a back-to-back frame
      set_in(1'b1, 2, 400, 1);
      trig(t);
      idle(1);
      trig(t1);
      exp_frame(t, 1'b1, 2, 400, 1);
      exp_frame(t + 5, 1'b1, 2, 400, 1);
      idle(14);
      compare("back_to_back");

      // Reset asserted during F_Y0
      set_in(1'b1, 8, 123, 11);
      trig(t);
      exp_frame(t, 1'b1, 8, 123, 11);
      void'(exp_q.pop_back());
      idle(3);
      #2 reset = 1'b0;
      #1;
      chk("midrst_cs",    96'(bus.cs),    96'(0));
      chk("midrst_write", 96'(bus.write), 96'(0));
      chk("midrst_busy",  96'(busy),      96'(0));
      idle(3);
      reset = 1'b1;
      x0m   = X_START;
      idle(4);
      compare("reset_mid");
      do_frame(1'b1, 9, 88, 19, "post_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
